// File: rtl/xillybus_rd128_arbiter_pkg.sv
// Shared definitions for the 128-bit Xillybus read-side source arbiter:
// FSM state codes, trailer magic and trailer field positions.
package xillybus_rd128_arbiter_pkg;

    localparam int unsigned WORD_W = 128;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_TRAIL = 2'd2;

    localparam logic [15:0] TRAILER_MAGIC = 16'hA5C3;

    // Trailer layout: magic, source id, word count, 7 zero bits, last flag, 87 zero bits
    localparam int unsigned TRL_MAGIC_LSB = 111;
    localparam int unsigned TRL_ID_LSB    = 103;
    localparam int unsigned TRL_COUNT_LSB = 95;
    localparam int unsigned TRL_LAST_BIT  = 87;

    function automatic logic [WORD_W-1:0] make_trailer(input logic [7:0] id,
                                                        input logic [7:0] count,
                                                        input logic       last_flag);
        logic [WORD_W-1:0] t;
        t = '0;
        t[TRL_MAGIC_LSB +: 16] = TRAILER_MAGIC;
        t[TRL_ID_LSB    +: 8]  = id;
        t[TRL_COUNT_LSB +: 8]  = count;
        t[TRL_LAST_BIT]        = last_flag;
        return t;
    endfunction

endpackage

// File: rtl/xillybus_rd128_arbiter_fifo.sv
// Synchronous 128-bit FIFO with standard (registered, non-FWFT) read data
// and a synchronous clear; read and write may coincide at full and at empty.
module xillybus_sync_fifo128
    import xillybus_rd128_arbiter_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_wr_en,
    input  logic [WORD_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    output logic [WORD_W-1:0] o_rd_data,
    output logic              o_full,
    output logic              o_empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [AW:0]       r_wptr;
    logic [AW:0]       r_rptr;
    logic [WORD_W-1:0] r_rd_data;
    logic              w_wr;
    logic              w_rd;

    assign o_empty   = (r_wptr == r_rptr);
    assign o_full    = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_rd      = i_rd_en && !o_empty;
    assign w_wr      = i_wr_en && (!o_full || w_rd);
    assign o_rd_data = r_rd_data;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wptr[AW-1:0]] <= i_wr_data;
        end
    end

    // Clear drops queued words but leaves the last presented read word alone
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_rd_data <= '0;
        end else if (i_clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + (AW+1)'(1);
            end
            if (w_rd) begin
                r_rd_data <= r_mem[r_rptr[AW-1:0]];
                r_rptr    <= r_rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/xillybus_rd128_arbiter.sv
// Round-robin arbiter merging NUM_SRC 128-bit producers into one Xillybus
// read stream; each burst is followed by a trailer word naming its source.
module xillybus_rd128_arbiter
    import xillybus_rd128_arbiter_pkg::*;
#(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned BURST_LEN  = 16,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                        bus_clk,
    input  logic                        bus_rst,
    input  logic [NUM_SRC*WORD_W-1:0]   src_data,
    input  logic [NUM_SRC-1:0]          src_valid,
    input  logic [NUM_SRC-1:0]          src_last,
    input  logic [NUM_SRC-1:0]          src_eof,
    output logic [NUM_SRC-1:0]          src_ready,
    input  logic                        user_r_read_128_rden,
    input  logic                        user_r_read_128_open,
    output logic [WORD_W-1:0]           user_r_read_128_data,
    output logic                        user_r_read_128_empty,
    output logic                        user_r_read_128_eof
);
    localparam int unsigned GW = $clog2(NUM_SRC);

    logic [1:0]        r_state, w_state_nxt;
    logic [GW-1:0]     r_grant, w_grant_nxt;
    logic [GW-1:0]     r_rr_ptr, w_rr_nxt;
    logic [7:0]        r_count, w_count_nxt;
    logic              r_last_flag, w_last_nxt;
    logic              r_eof, w_eof_nxt;
    logic [GW-1:0]     w_pick, w_cand;
    logic              w_found;
    logic              w_accept;
    logic              w_fifo_wr, w_fifo_full, w_fifo_empty;
    logic [WORD_W-1:0] w_fifo_wdata;
    logic [WORD_W-1:0] w_src_words [NUM_SRC];

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign w_src_words[gi] = src_data[gi*WORD_W +: WORD_W];
    end

    // First valid source at or after rr_ptr, wrapping modulo NUM_SRC
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_cand  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            w_cand = GW'((32'(r_rr_ptr) + i) % NUM_SRC);
            if (!w_found && src_valid[w_cand]) begin
                w_found = 1'b1;
                w_pick  = w_cand;
            end
        end
    end

    always_comb begin
        src_ready = '0;
        if (!bus_rst && user_r_read_128_open && r_state == ST_DATA && !w_fifo_full) begin
            src_ready[r_grant] = 1'b1;
        end
    end

    assign w_accept  = src_ready[r_grant] && src_valid[r_grant];
    assign w_eof_nxt = (&src_eof) && !(|src_valid) && (r_state == ST_IDLE) && w_fifo_empty;

    always_comb begin
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_rr_nxt     = r_rr_ptr;
        w_count_nxt  = r_count;
        w_last_nxt   = r_last_flag;
        w_fifo_wr    = 1'b0;
        w_fifo_wdata = w_src_words[r_grant];
        if (!user_r_read_128_open) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        w_grant_nxt = w_pick;
                        w_count_nxt = '0;
                        w_last_nxt  = 1'b0;
                        w_state_nxt = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_accept) begin
                        w_fifo_wr   = 1'b1;
                        w_count_nxt = r_count + 8'd1;
                        if (src_last[r_grant] || w_count_nxt == 8'(BURST_LEN)) begin
                            w_last_nxt  = src_last[r_grant];
                            w_state_nxt = ST_TRAIL;
                        end
                    end
                end
                ST_TRAIL: begin
                    if (!w_fifo_full) begin
                        w_fifo_wr    = 1'b1;
                        w_fifo_wdata = make_trailer(8'(r_grant), r_count, r_last_flag);
                        w_rr_nxt     = (r_grant == GW'(NUM_SRC-1)) ? '0 : r_grant + GW'(1);
                        w_state_nxt  = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            r_state     <= ST_IDLE;
            r_grant     <= '0;
            r_rr_ptr    <= '0;
            r_count     <= '0;
            r_last_flag <= 1'b0;
            r_eof       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_nxt;
            r_count     <= w_count_nxt;
            r_last_flag <= w_last_nxt;
            r_eof       <= w_eof_nxt;
        end
    end

    xillybus_sync_fifo128 #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .i_clk     (bus_clk),
        .i_rst     (bus_rst),
        .i_clr     (!user_r_read_128_open),
        .i_wr_en   (w_fifo_wr),
        .i_wr_data (w_fifo_wdata),
        .i_rd_en   (user_r_read_128_rden),
        .o_rd_data (user_r_read_128_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    assign user_r_read_128_empty = w_fifo_empty;
    assign user_r_read_128_eof   = r_eof;

endmodule

// File: tb/tb_xillybus_rd128_arbiter.sv
// Randomized bench: per-source word queues feed the arbiter; a stream-level
// model predicts grant order, burst splitting and trailers for the host side.
module tb_xillybus_rd128_arbiter;
    localparam int NS = 4;
    localparam int BL = 4;
    localparam int FD = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*128-1:0] src_data;
    logic [NS-1:0]     src_valid, src_last, src_eof, src_ready;
    logic              rden, open;
    logic [127:0]      rd_data;
    logic              empty, eof;
    logic [127:0]      drv_word [NS];

    for (genvar g = 0; g < NS; g++) begin : g_pack
        assign src_data[g*128 +: 128] = drv_word[g];
    end

    xillybus_rd128_arbiter #(.NUM_SRC(NS), .BURST_LEN(BL), .FIFO_DEPTH(FD)) dut (
        .bus_clk               (clk),
        .bus_rst               (rst),
        .src_data              (src_data),
        .src_valid             (src_valid),
        .src_last              (src_last),
        .src_eof               (src_eof),
        .src_ready             (src_ready),
        .user_r_read_128_rden  (rden),
        .user_r_read_128_open  (open),
        .user_r_read_128_data  (rd_data),
        .user_r_read_128_empty (empty),
        .user_r_read_128_eof   (eof)
    );

    always #5 clk = ~clk;

    logic [127:0] sd [NS][64];
    logic         sl [NS][64];
    int           head [NS];
    int           tail [NS];
    logic [127:0] exp_q [$];
    int           rr, bsrc, bcnt, rd_pct, gap_pct;
    bit           in_burst, rd_pend, host_en, open_drv, eof_drv;
    int           n_checks = 0;
    int           n_pass = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [127:0] trailer(input int id, input int cnt, input logic lf);
        logic [7:0] i8;
        logic [7:0] c8;
        i8 = 8'(id);
        c8 = 8'(cnt);
        return 128'({16'hA5C3, i8, c8, 7'b0, lf, 87'b0});
    endfunction

    function automatic int next_src();
        int c;
        for (int k = 0; k < NS; k++) begin
            c = (rr + k) % NS;
            if (head[c] != tail[c]) return c;
        end
        return -1;
    endfunction

    function automatic int pending();
        int p;
        p = exp_q.size() + int'(in_burst) + int'(rd_pend);
        for (int s = 0; s < NS; s++) p += tail[s] - head[s];
        return p;
    endfunction

    task automatic load(input int s, input int n, input bit rnd_last);
        if (head[s] == tail[s]) begin
            head[s] = 0;
            tail[s] = 0;
        end
        for (int k = 0; k < n; k++) begin
            sd[s][tail[s]] = {$urandom, $urandom, $urandom, $urandom};
            sl[s][tail[s]] = (k == n - 1) || (rnd_last && $urandom_range(0, 3) == 0);
            tail[s]++;
        end
    endtask

    task automatic drive();
        for (int s = 0; s < NS; s++) begin
            if (head[s] != tail[s] &&
                !(in_burst && s == bsrc && $urandom_range(0, 99) < gap_pct)) begin
                src_valid[s] = 1'b1;
                src_last[s]  = sl[s][head[s]];
                drv_word[s]  = sd[s][head[s]];
            end else begin
                src_valid[s] = 1'b0;
                src_last[s]  = 1'b0;
                drv_word[s]  = '0;
            end
        end
        src_eof = eof_drv ? '1 : '0;
        open    = open_drv;
        rden    = host_en && ($urandom_range(0, 99) < rd_pct);
    endtask

    // Model: a burst opens on its first accepted word and closes on last or the cap
    task automatic accept(input int s);
        logic lf;
        if (!in_burst) begin
            check("grant", 128'(s), 128'(next_src()));
            in_burst = 1'b1;
            bsrc     = s;
            bcnt     = 0;
        end else begin
            check("burst_src", 128'(s), 128'(bsrc));
        end
        exp_q.push_back(sd[s][head[s]]);
        lf = sl[s][head[s]];
        head[s]++;
        bcnt++;
        if (lf || bcnt == BL) begin
            exp_q.push_back(trailer(bsrc, bcnt, lf));
            rr       = (bsrc + 1) % NS;
            in_burst = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        if (rd_pend) begin
            check("rd_avail", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) check("rdata", rd_data, exp_q.pop_front());
        end
        drive();
        #1;
        check("rdy_onehot", 128'($countones(src_ready) <= 1), 128'(1));
        if (!open_drv) check("rdy_closed", 128'(src_ready), 128'(0));
        if (!eof_drv) check("eof_low", 128'(eof), 128'(0));
        rd_pend = rden && !empty && open_drv;
        for (int s = 0; s < NS; s++) begin
            if (src_valid[s] && src_ready[s]) accept(s);
        end
    endtask

    task automatic drain(input int bound);
        int cyc;
        cyc = 0;
        while (pending() != 0 && cyc < bound) begin
            step();
            cyc++;
        end
        check("drain_left", 128'(pending()), 128'(0));
    endtask

    initial begin
        for (int s = 0; s < NS; s++) begin
            head[s] = 0;
            tail[s] = 0;
        end
        rr = 0; bsrc = 0; bcnt = 0;
        in_burst = 1'b0; rd_pend = 1'b0;
        host_en = 1'b0; open_drv = 1'b1; eof_drv = 1'b0;
        rd_pct = 100; gap_pct = 0;
        rst = 1'b1;
        drive();
        repeat (3) @(negedge clk);
        check("rst_empty", 128'(empty), 128'(1));
        check("rst_eof", 128'(eof), 128'(0));
        check("rst_data", rd_data, 128'(0));
        check("rst_ready", 128'(src_ready), 128'(0));
        rst = 1'b0;
        step();
        check("post_rst_empty", 128'(empty), 128'(1));

        // Single source, 3-word packet
        host_en = 1'b1;
        load(0, 3, 1'b0);
        drain(200);

        // Burst cap splits 10 words from source 1 into 4, 4, 2
        rd_pct = 50;
        load(1, 10, 1'b0);
        drain(400);

        // All sources busy: round-robin rotation and wrap
        for (int s = 0; s < NS; s++) load(s, 8, 1'b0);
        drain(800);

        // Random traffic with valid gaps and host stalls
        gap_pct = 20;
        for (int r = 0; r < 4; r++) begin
            rd_pct = $urandom_range(30, 100);
            for (int s = 0; s < NS; s++) begin
                if ($urandom_range(0, 3) != 0) load(s, $urandom_range(1, 12), 1'b1);
            end
            drain(3000);
        end

        // Backpressure: host stalled until the FIFO fills
        host_en = 1'b0;
        load(0, 20, 1'b0);
        repeat (60) step();
        check("bp_queued", 128'(exp_q.size()), 128'(FD));
        check("bp_ready", 128'(src_ready), 128'(0));
        check("bp_empty", 128'(empty), 128'(1'b0));
        host_en = 1'b1;
        rd_pct = 70;
        drain(1000);

        // Close mid-burst after 2 of 5 words
        host_en = 1'b0;
        load(3, 5, 1'b0);
        begin
            int cyc;
            cyc = 0;
            while (!(in_burst && bcnt == 2) && cyc < 200) begin
                step();
                cyc++;
            end
        end
        check("close_words", 128'(bcnt), 128'(2));
        open_drv = 1'b0;
        step();
        exp_q.delete();
        in_burst = 1'b0;
        bcnt = 0;
        @(negedge clk);
        check("close_empty", 128'(empty), 128'(1));
        check("close_ready", 128'(src_ready), 128'(0));
        load(0, 2, 1'b0);
        repeat (3) step();
        open_drv = 1'b1;
        host_en = 1'b1;
        drain(400);

        // End of stream: eof rises once idle and drained, falls after new data
        eof_drv = 1'b1;
        repeat (3) step();
        check("eof_set", 128'(eof), 128'(1));
        check("eof_empty", 128'(empty), 128'(1));
        load(2, 1, 1'b0);
        step();
        check("eof_hold", 128'(eof), 128'(1));
        @(posedge clk);
        #1;
        check("eof_drop", 128'(eof), 128'(0));
        drain(200);
        repeat (3) step();
        check("eof_reset", 128'(eof), 128'(1));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
